// File: rtl/pipe_pkg.sv
// Shared types and defaults for the MEM->WB pipeline register slice.
// Holds the writeback result-select encoding, the W-stage control bundle
// and the helper that decides whether an instruction may write the regfile.
package pipe_pkg;

  // Default widths used when the top is instantiated without overrides
  localparam int WIDTH_DEF  = 32;
  localparam int REG_AW_DEF = 5;
  localparam int RES_W_DEF  = 2;

  // Writeback mux select: which value is written back to the regfile
  typedef enum logic [RES_W_DEF-1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } resultsrc_e;

  // Control bundle carried from M to W at the default select width
  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic [RES_W_DEF-1:0] resultsrc;
  } ctrl_mw_t;

  // A write is only real when the instruction exists, asks to write,
  // and does not target x0, which must always read as zero.
  function automatic logic qualify_write(input logic valid,
                                         input logic regwrite,
                                         input logic rdNonZero);
    return valid & regwrite & rdNonZero;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic enable/clear pipeline flop used for both halves of the MEM->WB latch.
// clr has priority over en so a bubble can be forced even while the stage
// is being held; asynchronous active-high reset clears the contents.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset and clear force zero, otherwise capture only when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_mw_reg.sv
// MEM->WB pipeline register with valid tracking, stall (hold) and flush (bubble).
// Control fields (valid, regwrite, resultsrc, rd) are cleared on flush; the
// wide data fields are only enabled by !stallW and are don't-care in a bubble.
// regwriteW is qualified at load time so x0 writes and invalid slots never
// reach the regfile; fwdvalidW is derived purely from W-side registers.
// Optional build macro PIPE_MW_PERF_EN adds retire/stall/bubble counters.
module pipe_mw_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int RES_W     = RES_W_DEF
`ifdef PIPE_MW_PERF_EN
  ,
  parameter int CNT_WIDTH = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallW,
  input  logic              flushW,
  input  logic              validM,
  input  logic              regwriteM,
  input  logic [RES_W-1:0]  resultsrcM,
  input  logic [WIDTH-1:0]  readdataM,
  input  logic [WIDTH-1:0]  aluresultM,
  input  logic [REG_AW-1:0] rdM,
  input  logic [WIDTH-1:0]  pcplus4M,
  output logic              validW,
  output logic              regwriteW,
  output logic [RES_W-1:0]  resultsrcW,
  output logic [WIDTH-1:0]  readdataW,
  output logic [WIDTH-1:0]  aluresultW,
  output logic [REG_AW-1:0] rdW,
  output logic [WIDTH-1:0]  pcplus4W,
  output logic              fwdvalidW
`ifdef PIPE_MW_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] retire_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] bubble_cnt
`endif
);

  localparam int CTRL_W = 2 + RES_W + REG_AW;
  localparam int DATA_W = 3 * WIDTH;

  logic              loadEn;
  logic              writeQual;
  logic [CTRL_W-1:0] ctrlD;
  logic [CTRL_W-1:0] ctrlQ;
  logic [DATA_W-1:0] dataD;
  logic [DATA_W-1:0] dataQ;

  // Stall freezes every W-side register; flush overrides it via clr
  assign loadEn    = ~stallW;
  assign writeQual = qualify_write(validM, regwriteM, rdM != '0);

  assign ctrlD = {validM, writeQual, resultsrcM, rdM};
  assign dataD = {readdataM, aluresultM, pcplus4M};

  // Control half: becomes a bubble (all zero) whenever flushW is high
  pipe_reg #(.W(CTRL_W)) u_ctrl (
    .clk (clk),
    .rst (rst),
    .en  (loadEn),
    .clr (flushW),
    .d   (ctrlD),
    .q   (ctrlQ)
  );

  // Data half: never cleared, contents are ignored while validW is low
  pipe_reg #(.W(DATA_W)) u_data (
    .clk (clk),
    .rst (rst),
    .en  (loadEn),
    .clr (1'b0),
    .d   (dataD),
    .q   (dataQ)
  );

  assign validW     = ctrlQ[CTRL_W-1];
  assign regwriteW  = ctrlQ[CTRL_W-2];
  assign resultsrcW = ctrlQ[REG_AW +: RES_W];
  assign rdW        = ctrlQ[REG_AW-1:0];

  assign readdataW  = dataQ[2*WIDTH +: WIDTH];
  assign aluresultW = dataQ[WIDTH +: WIDTH];
  assign pcplus4W   = dataQ[WIDTH-1:0];

  // regwriteW already implies rdW != 0, so no comparator is needed here
  assign fwdvalidW  = validW & regwriteW;

`ifdef PIPE_MW_PERF_EN
  logic bubbleLoad;

  // An edge produces a bubble when flushing or when loading an empty M slot
  assign bubbleLoad = flushW | (~stallW & ~validM);

  // Free-running event counters, wrapping naturally at CNT_WIDTH bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (validW && !stallW) begin
        retire_cnt <= retire_cnt + CNT_WIDTH'(1);
      end
      if (stallW) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
      if (bubbleLoad) begin
        bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mw_reg.sv
// Self-checking bench for pipe_mw_reg: directed scenarios plus random traffic
// compared against a transaction-level model of the W stage.
// Define PIPE_MW_PERF_EN to also exercise the performance counters.
module tb_pipe_mw_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallW, flushW, validM, regwriteM;
  logic [1:0]  resultsrcM;
  logic [31:0] readdataM, aluresultM, pcplus4M;
  logic [4:0]  rdM;
  logic        validW, regwriteW, fwdvalidW;
  logic [1:0]  resultsrcW;
  logic [31:0] readdataW, aluresultW, pcplus4W;
  logic [4:0]  rdW;

  int checks   = 0;
  int failures = 0;

  // Model of what the W stage should hold
  logic        mValid, mRegwrite, mDataKnown;
  logic [1:0]  mRes;
  logic [4:0]  mRd;
  logic [31:0] mRead, mAlu, mPc;
  longint unsigned mRetire, mStall, mBubble;

  always #5 clk = ~clk;

`ifdef PIPE_MW_PERF_EN
  logic [31:0] retire_cnt, stall_cnt, bubble_cnt;
  logic [3:0]  nRetire, nStall, nBubble;
  logic        nValidW, nRegwriteW, nFwdvalidW;
  logic [1:0]  nResultsrcW;
  logic [31:0] nReaddataW, nAluresultW, nPcplus4W;
  logic [4:0]  nRdW;
`endif

  pipe_mw_reg dut (
    .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW),
    .validM(validM), .regwriteM(regwriteM), .resultsrcM(resultsrcM),
    .readdataM(readdataM), .aluresultM(aluresultM), .rdM(rdM),
    .pcplus4M(pcplus4M), .validW(validW), .regwriteW(regwriteW),
    .resultsrcW(resultsrcW), .readdataW(readdataW), .aluresultW(aluresultW),
    .rdW(rdW), .pcplus4W(pcplus4W), .fwdvalidW(fwdvalidW)
`ifdef PIPE_MW_PERF_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

`ifdef PIPE_MW_PERF_EN
  pipe_mw_reg #(.CNT_WIDTH(4)) dutNarrow (
    .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW),
    .validM(validM), .regwriteM(regwriteM), .resultsrcM(resultsrcM),
    .readdataM(readdataM), .aluresultM(aluresultM), .rdM(rdM),
    .pcplus4M(pcplus4M), .validW(nValidW), .regwriteW(nRegwriteW),
    .resultsrcW(nResultsrcW), .readdataW(nReaddataW), .aluresultW(nAluresultW),
    .rdW(nRdW), .pcplus4W(nPcplus4W), .fwdvalidW(nFwdvalidW),
    .retire_cnt(nRetire), .stall_cnt(nStall), .bubble_cnt(nBubble)
  );
`endif

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mValid = 1'b0; mRegwrite = 1'b0; mRes = '0; mRd = '0;
    mRead = '0; mAlu = '0; mPc = '0; mDataKnown = 1'b1;
    mRetire = 0; mStall = 0; mBubble = 0;
  endtask

  // Compare every W output against the model
  task automatic checkAll(input string tag);
    checkOutput({tag, ".validW"}, validW, mValid);
    checkOutput({tag, ".regwriteW"}, regwriteW, mRegwrite);
    checkOutput({tag, ".resultsrcW"}, resultsrcW, mRes);
    checkOutput({tag, ".rdW"}, rdW, mRd);
    checkOutput({tag, ".fwdvalidW"}, fwdvalidW, mValid && mRegwrite);
    if (mDataKnown) begin
      checkOutput({tag, ".readdataW"}, readdataW, mRead);
      checkOutput({tag, ".aluresultW"}, aluresultW, mAlu);
      checkOutput({tag, ".pcplus4W"}, pcplus4W, mPc);
    end
`ifdef PIPE_MW_PERF_EN
    checkOutput({tag, ".retire_cnt"}, retire_cnt, mRetire % (64'd1 << 32));
    checkOutput({tag, ".stall_cnt"}, stall_cnt, mStall % (64'd1 << 32));
    checkOutput({tag, ".bubble_cnt"}, bubble_cnt, mBubble % (64'd1 << 32));
    checkOutput({tag, ".n_retire"}, nRetire, mRetire % 16);
    checkOutput({tag, ".n_stall"}, nStall, mStall % 16);
    checkOutput({tag, ".n_bubble"}, nBubble, mBubble % 16);
    checkOutput({tag, ".n_validW"}, nValidW, mValid);
`endif
  endtask

  // Drive one cycle of M-side inputs, advance the model across the edge, then check
  task automatic applyStimulus(input string tag, input logic stall, input logic flush,
                               input logic vM, input logic rwM, input logic [1:0] res,
                               input logic [4:0] rd, input logic [31:0] rdata,
                               input logic [31:0] alu, input logic [31:0] pc);
    stallW = stall; flushW = flush; validM = vM; regwriteM = rwM;
    resultsrcM = res; rdM = rd; readdataM = rdata; aluresultM = alu; pcplus4M = pc;
    @(posedge clk);
    if (mValid && !stall) mRetire++;
    if (stall) mStall++;
    if (flush) begin
      mBubble++;
      mValid = 1'b0; mRegwrite = 1'b0; mRes = '0; mRd = '0; mDataKnown = 1'b0;
    end else if (!stall) begin
      if (!vM) mBubble++;
      mValid = vM;
      mRegwrite = vM && rwM && (rd != 0);
      mRes = res; mRd = rd; mRead = rdata; mAlu = alu; mPc = pc; mDataKnown = 1'b1;
    end
    @(negedge clk);
    checkAll(tag);
  endtask

  initial begin
    // Reset with busy-looking M inputs: W must still read as empty
    rst = 1'b1; stallW = 1'b0; flushW = 1'b0; validM = 1'b1; regwriteM = 1'b1;
    resultsrcM = 2'd2; rdM = 5'd9; readdataM = 32'h11111111;
    aluresultM = 32'h22222222; pcplus4M = 32'h33333333;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll("reset");
    rst = 1'b0;

    // Basic one-cycle transfer
    applyStimulus("t1", 0, 0, 1, 1, RES_ALU, 5'd5, 32'h0, 32'hDEADBEEF, 32'h104);
    checkOutput("t1.alu_const", aluresultW, 32'hDEADBEEF);
    checkOutput("t1.rd_const", rdW, 5'd5);
    checkOutput("t1.rw_const", regwriteW, 1'b1);

    // Three stalled cycles while M keeps changing, then release
    for (int i = 0; i < 3; i++)
      applyStimulus("t2.stall", 1, 0, 1, 1, RES_MEM, 5'(10 + i), 32'(i), 32'(100 + i), 32'(200 + i));
    checkOutput("t2.frozen_alu", aluresultW, 32'hDEADBEEF);
    applyStimulus("t2.release", 0, 0, 1, 1, RES_MEM, 5'd12, 32'hCAFE0000, 32'h55, 32'h208);
    checkOutput("t2.loaded_rd", rdW, 5'd12);

    // Flush beats stall
    applyStimulus("t3", 1, 1, 1, 1, RES_PC4, 5'd7, 32'h1, 32'h2, 32'h3);
    checkOutput("t3.validW", validW, 1'b0);
    checkOutput("t3.rdW", rdW, 5'd0);

    // x0 destination: valid but never writes
    applyStimulus("t4", 0, 0, 1, 1, RES_ALU, 5'd0, 32'h4, 32'h5, 32'h6);
    checkOutput("t4.validW", validW, 1'b1);
    checkOutput("t4.fwdvalidW", fwdvalidW, 1'b0);

    // Invalid M loads as bubble even with regwriteM set
    applyStimulus("t4b", 0, 0, 0, 1, RES_MEM, 5'd3, 32'h7, 32'h8, 32'h9);
    applyStimulus("t5.pre", 0, 0, 1, 1, RES_MEM, 5'd21, 32'hA, 32'hB, 32'hC);

    // Asynchronous reset pulse mid-stall, between clock edges
    stallW = 1'b1;
    #1 rst = 1'b1;
    #1;
    checkOutput("t5.async_validW", validW, 1'b0);
    checkOutput("t5.async_rdW", rdW, 5'd0);
    checkOutput("t5.async_alu", aluresultW, 32'h0);
    modelReset();
    #1 rst = 1'b0;
    applyStimulus("t5.post", 1, 0, 1, 1, RES_ALU, 5'd4, 32'h1, 32'h2, 32'h3);

`ifdef PIPE_MW_PERF_EN
    // Counter scenario: 4 loads, 2 stalls, 1 flush from a clean reset
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    modelReset();
    for (int i = 0; i < 4; i++)
      applyStimulus("t6.load", 0, 0, 1, 1, RES_ALU, 5'(i + 1), 32'(i), 32'(i), 32'(i));
    for (int i = 0; i < 2; i++)
      applyStimulus("t6.stall", 1, 0, 1, 1, RES_ALU, 5'd9, 32'h0, 32'h0, 32'h0);
    applyStimulus("t6.flush", 0, 1, 1, 1, RES_ALU, 5'd9, 32'h0, 32'h0, 32'h0);
    checkOutput("t6.retire_const", retire_cnt, 32'd4);
    checkOutput("t6.stall_const", stall_cnt, 32'd2);
    checkOutput("t6.bubble_const", bubble_cnt, 32'd1);

    // 17 retirements wrap a 4-bit counter to 1
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    modelReset();
    for (int i = 0; i < 18; i++)
      applyStimulus("t6.wrap", 0, 0, 1, 0, RES_MEM, 5'd1, 32'(i), 32'(i), 32'(i));
    checkOutput("t6.wrap_narrow", nRetire, 4'd1);
    checkOutput("t6.wrap_wide", retire_cnt, 32'd17);
`endif

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic s, f, v, w;
      logic [1:0] r;
      logic [4:0] d;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 9) == 0);
      v = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0: r = RES_ALU;
        1: r = RES_MEM;
        default: r = RES_PC4;
      endcase
      d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      applyStimulus("rand", s, f, v, w, r, d, $urandom, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
